mux_arb_rr_n: RTL and testbench

- Parametrised successor to the combinational 4:1 data mux: CH input channels, each N bits wide, each with a valid/ready handshake.
- Merged onto one registered output port.
- Two modes: fixed select (sel input, like the legacy mux) and round-robin arbitration.
- Used in the processor datapath where several producers share one consumer, e.g. writeback or bus request merging.

---
 rtl/mux_arb_rr_n.sv | 148 ++++++++++++++
 tb/tb_mux_arb_rr_n.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mux_arb_rr_n.sv
// mux_arb_rr_n: merges CH valid/ready input channels (N bits each) onto one
// registered output port. There are two grant modes: fixed select through
// `sel`, and round-robin arbitration that starts from a rotating pointer.
// The output stage is a one-entry buffer. It can drain and refill on the
// same edge, so it sustains one word per cycle.
//
// Ports:
//   clk, rst            rising-edge clock, async active-high reset
//   mode                0 = fixed select via sel, 1 = round-robin
//   sel [SW]            channel index used when mode = 0
//   in_data [CH*N]      channel i at bits [i*N +: N]
//   in_valid/in_ready   per-channel handshake; in_ready is one-hot or zero
//   out_data/out_valid  registered output word and valid
//   out_ready           downstream ready
//   out_sel [SW]        index of the channel whose word is held
//   xfer_count [16]     output transfer counter, wraps at 16'hFFFF
//                       (only present when MUX_ARB_XFER_CNT_EN is defined)

// Per-channel slice: qualifies the ready for this channel and masks its data
// so that the top level can build the mux as a plain OR-reduce.
module mux_arb_rr_n_lane #(
  parameter int N = 4
) (
  input  logic         gnt,
  input  logic         load_en,
  input  logic         rst,
  input  logic [N-1:0] data,
  output logic         ready,
  output logic [N-1:0] data_m
);
  assign ready  = gnt & load_en & ~rst;
  assign data_m = gnt ? data : '0;
endmodule

module mux_arb_rr_n #(
  parameter int N  = 4,
  parameter int CH = 4,
  parameter int SW = $clog2(CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  input  logic [CH*N-1:0] in_data,
  input  logic [CH-1:0]   in_valid,
  output logic [CH-1:0]   in_ready,
  output logic [N-1:0]    out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SW-1:0]   out_sel
`ifdef MUX_ARB_XFER_CNT_EN
  ,
  output logic [15:0]     xfer_count
`endif
);

  logic                  load_en;
  logic                  accept;
  logic                  gnt_any;
  logic [SW-1:0]         g;
  logic [SW-1:0]         ptr;
  logic [SW-1:0]         g_nxt;
  logic [CH-1:0]         gnt_oh;
  logic [CH-1:0][N-1:0]  data_m;
  logic [N-1:0]          data_sel;

  // The output slot is free when it is empty, or when it is draining on this edge.
  assign load_en = !out_valid || out_ready;

  // Grant decision. In round-robin mode the scan runs from the top offset
  // down to the bottom one, so the last match kept is the first valid channel
  // at or after ptr.
  always_comb begin
    int idx;
    g       = '0;
    gnt_any = 1'b0;
    idx     = 0;
    if (!mode) begin
      // When CH is not a power of two, sel can point past the last channel.
      // No grant is given in that case.
      if (int'(sel) < CH) begin
        if (in_valid[sel]) begin
          g       = sel;
          gnt_any = 1'b1;
        end
      end
    end else begin
      for (int k = CH - 1; k >= 0; k--) begin
        idx = (int'(ptr) + k) % CH;
        if (in_valid[idx]) begin
          g       = SW'(idx);
          gnt_any = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < CH; i++)
      gnt_oh[i] = gnt_any && (g == SW'(i));
  end

  for (genvar i = 0; i < CH; i++) begin : g_lane
    mux_arb_rr_n_lane #(.N(N)) u_lane (
      .gnt     (gnt_oh[i]),
      .load_en (load_en),
      .rst     (rst),
      .data    (in_data[i*N +: N]),
      .ready   (in_ready[i]),
      .data_m  (data_m[i])
    );
  end

  always_comb begin
    data_sel = '0;
    for (int i = 0; i < CH; i++)
      data_sel = data_sel | data_m[i];
  end

  // A grant always implies that the granted channel is valid, so the
  // handshake completes exactly when the slot is free.
  assign accept = gnt_any && load_en;
  assign g_nxt  = (g == SW'(CH - 1)) ? '0 : g + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= data_sel;
      out_sel   <= g;
      if (mode) ptr <= g_nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MUX_ARB_XFER_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        xfer_count <= '0;
    else if (out_valid && out_ready) xfer_count <= xfer_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mux_arb_rr_n.sv
module tb_mux_arb_rr_n;
  localparam int N  = 4;
  localparam int CH = 4;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            mode = 1'b0;
  logic [SW-1:0]   sel = '0;
  logic [CH*N-1:0] in_data = '0;
  logic [CH-1:0]   in_valid = '0;
  logic [CH-1:0]   in_ready;
  logic [N-1:0]    out_data;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [SW-1:0]   out_sel;
`ifdef MUX_ARB_XFER_CNT_EN
  logic [15:0]     xfer_count;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux_arb_rr_n #(.N(N), .CH(CH)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel)
`ifdef MUX_ARB_XFER_CNT_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs applied for one cycle, the in_ready expected before the edge, and
  // the register contents expected after the edge.
  typedef struct {
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  v;
    logic [15:0] d;
    logic        ordy;
    logic [3:0]  rdy;
    logic        ov;
    logic [3:0]  od;
    logic [1:0]  os;
  } vec_t;

  localparam logic [15:0] D0 = 16'h8421;
  localparam logic [15:0] DA = 16'hA421;

  vec_t tv[26];

  initial begin
    // fixed-select legacy equivalence
    tv[0]  = '{1'b0, 2'd0, 4'hF, D0, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0};
    tv[1]  = '{1'b0, 2'd1, 4'hF, D0, 1'b1, 4'b0010, 1'b1, 4'h2, 2'd1};
    tv[2]  = '{1'b0, 2'd2, 4'hF, D0, 1'b1, 4'b0100, 1'b1, 4'h4, 2'd2};
    tv[3]  = '{1'b0, 2'd3, 4'hF, D0, 1'b1, 4'b1000, 1'b1, 4'h8, 2'd3};
    // round-robin fairness over 8 cycles
    for (int i = 0; i < 8; i++) begin
      tv[4+i] = '{1'b1, 2'd0, 4'hF, D0, 1'b1, 4'b0001 << (i % 4), 1'b1,
                  4'b0001 << (i % 4), 2'(i % 4)};
    end
    // only ch1 and ch3 valid: pointer skips the idle channels
    tv[12] = '{1'b1, 2'd0, 4'hA, D0, 1'b1, 4'b0010, 1'b1, 4'h2, 2'd1};
    tv[13] = '{1'b1, 2'd0, 4'hA, D0, 1'b1, 4'b1000, 1'b1, 4'h8, 2'd3};
    tv[14] = '{1'b1, 2'd0, 4'hA, D0, 1'b1, 4'b0010, 1'b1, 4'h2, 2'd1};
    // idle drain, then resume from saved ptr = 2
    tv[15] = '{1'b1, 2'd0, 4'h0, D0, 1'b1, 4'b0000, 1'b0, 4'h2, 2'd1};
    tv[16] = '{1'b1, 2'd0, 4'hF, D0, 1'b1, 4'b0100, 1'b1, 4'h4, 2'd2};
    // load 4'hA, hold it for 3 backpressured cycles, then refill with no bubble
    tv[17] = '{1'b1, 2'd0, 4'hF, DA, 1'b1, 4'b1000, 1'b1, 4'hA, 2'd3};
    tv[18] = '{1'b1, 2'd0, 4'hF, DA, 1'b0, 4'b0000, 1'b1, 4'hA, 2'd3};
    tv[19] = '{1'b1, 2'd0, 4'hF, DA, 1'b0, 4'b0000, 1'b1, 4'hA, 2'd3};
    tv[20] = '{1'b1, 2'd0, 4'hF, DA, 1'b0, 4'b0000, 1'b1, 4'hA, 2'd3};
    tv[21] = '{1'b1, 2'd0, 4'hF, DA, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0};
    // fixed select on a non-valid channel: no grant, drain, ptr kept (1)
    tv[22] = '{1'b0, 2'd2, 4'hB, DA, 1'b1, 4'b0000, 1'b0, 4'h1, 2'd0};
    tv[23] = '{1'b1, 2'd0, 4'hF, DA, 1'b1, 4'b0010, 1'b1, 4'h2, 2'd1};
    // fixed-mode backpressure, then accept; held word unaffected by sel change
    tv[24] = '{1'b0, 2'd3, 4'hF, DA, 1'b0, 4'b0000, 1'b1, 4'h2, 2'd1};
    tv[25] = '{1'b0, 2'd3, 4'hF, DA, 1'b1, 4'b1000, 1'b1, 4'hA, 2'd3};
  end

  initial begin
    // reset asserted with every channel valid: ready must stay low
    mode = 1'b1; in_valid = 4'hF; in_data = D0; out_ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data",  32'(out_data),  32'd0);
    chk("reset out_sel",   32'(out_sel),   32'd0);
    chk("reset in_ready",  32'(in_ready),  32'd0);
    @(posedge clk); #1;
    chk("reset hold in_ready", 32'(in_ready), 32'd0);
    chk("reset hold out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 26; i++) begin
      mode = tv[i].mode; sel = tv[i].sel; in_valid = tv[i].v;
      in_data = tv[i].d; out_ready = tv[i].ordy;
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(tv[i].rdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(tv[i].ov));
      chk($sformatf("v%0d out_data", i),  32'(out_data),  32'(tv[i].od));
      chk($sformatf("v%0d out_sel", i),   32'(out_sel),   32'(tv[i].os));
    end

    // Mid-cycle reset while a word is held: everything clears at once.
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst out_data",  32'(out_data),  32'd0);
    chk("midrst out_sel",   32'(out_sel),   32'd0);
    chk("midrst in_ready",  32'(in_ready),  32'd0);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    #1;
    chk("post-rst first grant", 32'(in_ready), 32'b0001);
    @(posedge clk); #1;
    chk("post-rst out_sel",   32'(out_sel),   32'd0);
    chk("post-rst out_data",  32'(out_data),  32'h1);
    chk("post-rst out_valid", 32'(out_valid), 32'd1);

`ifdef MUX_ARB_XFER_CNT_EN
    // The first edge only loads, and each of the following 65537 edges
    // completes one transfer, so the counter wraps and ends at 1.
    rst = 1'b1; #1;
    chk("cnt reset", 32'(xfer_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    for (int i = 0; i < 65538; i++) begin
      @(posedge clk);
    end
    #1;
    chk("cnt wrap", 32'(xfer_count), 32'd1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
    end
    #1;
    chk("cnt stall", 32'(xfer_count), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
